// File: rtl/sort_ctrl.sv
// Sequencer for the serial selection-sort datapath: loads DEPTH operands, runs DEPTH
// compare/rotate passes (one maximum committed per pass), drains the ring, then pulses done.
module sort_ctrl #(
    parameter int DEPTH = 9,
    parameter int CW    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic valid_i,
    input  logic out_ready_i,
    input  logic eh_maior_i,
    output logic en_sr_o,
    output logic mux_in_o,
    output logic wr_bigger_o,
    output logic wr_last_o,
    output logic wr_counter_o,
    output logic rst_counter_o,
    output logic load_ready_o,
    output logic out_valid_o,
    output logic busy_o,
    output logic done_o
);

    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEED  = 3'd2,
        ST_COMP  = 3'd3,
        ST_LAST  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] step_cnt_reg, step_cnt_next;
    logic [CW-1:0] pass_cnt_reg, pass_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            step_cnt_reg <= '0;
            pass_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            step_cnt_reg <= step_cnt_next;
            pass_cnt_reg <= pass_cnt_next;
        end
    end

    // Every phase exit clears the counter it used, so counters never exceed DEPTH-1.
    always_comb begin
        state_next    = state_reg;
        step_cnt_next = step_cnt_reg;
        pass_cnt_next = pass_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    step_cnt_next = '0;
                    pass_cnt_next = '0;
                    state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (valid_i) begin
                    if (step_cnt_reg == LAST_IDX) begin
                        step_cnt_next = '0;
                        state_next    = ST_SEED;
                    end else begin
                        step_cnt_next = step_cnt_reg + CW'(1);
                    end
                end
            end
            ST_SEED: begin
                state_next = ST_COMP;
            end
            ST_COMP: begin
                if (step_cnt_reg == LAST_IDX) begin
                    step_cnt_next = '0;
                    state_next    = ST_LAST;
                end else begin
                    step_cnt_next = step_cnt_reg + CW'(1);
                end
            end
            ST_LAST: begin
                if (pass_cnt_reg == LAST_IDX) begin
                    pass_cnt_next = '0;
                    state_next    = ST_DRAIN;
                end else begin
                    pass_cnt_next = pass_cnt_reg + CW'(1);
                    state_next    = ST_SEED;
                end
            end
            ST_DRAIN: begin
                if (out_ready_i) begin
                    if (step_cnt_reg == LAST_IDX) begin
                        step_cnt_next = '0;
                        state_next    = ST_DONE;
                    end else begin
                        step_cnt_next = step_cnt_reg + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next    = ST_IDLE;
                step_cnt_next = '0;
                pass_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        en_sr_o       = 1'b0;
        mux_in_o      = 1'b0;
        wr_bigger_o   = 1'b0;
        wr_last_o     = 1'b0;
        wr_counter_o  = 1'b0;
        rst_counter_o = 1'b0;
        load_ready_o  = 1'b0;
        out_valid_o   = 1'b0;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy_o = 1'b0;
                // Gated by rst so the datapath clear cannot fire while held in reset.
                rst_counter_o = start_i & ~rst;
            end
            ST_LOAD: begin
                load_ready_o = 1'b1;
                en_sr_o      = valid_i;
            end
            ST_SEED: begin
                wr_bigger_o = 1'b1;
            end
            ST_COMP: begin
                en_sr_o     = 1'b1;
                mux_in_o    = 1'b1;
                wr_bigger_o = eh_maior_i;
            end
            ST_LAST: begin
                wr_last_o    = 1'b1;
                wr_counter_o = 1'b1;
            end
            ST_DRAIN: begin
                out_valid_o = 1'b1;
                mux_in_o    = 1'b1;
                en_sr_o     = out_ready_i;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sort_ctrl.sv
module tb_sort_ctrl;

    localparam int DEPTH = 9;
    localparam int WAIT_LIMIT = 200;

    localparam int B_EN = 9, B_MUX = 8, B_WB = 7, B_WL = 6, B_WC = 5;
    localparam int B_RC = 4, B_LR = 3, B_OV = 2, B_BUSY = 1, B_DONE = 0;

    typedef struct {
        logic       start;
        logic       valid;
        logic       ready;
        logic       eh;
        logic       rst_mid;
        logic       rst_hold;
        logic [9:0] exp;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0, valid_i = 1'b0, out_ready_i = 1'b0, eh_maior_i = 1'b0;
    logic en_sr_o, mux_in_o, wr_bigger_o, wr_last_o, wr_counter_o, rst_counter_o;
    logic load_ready_o, out_valid_o, busy_o, done_o;

    item_t      plan_q[$];
    logic [9:0] sb_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         idle_wait = 0;
    bit         running = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_ctrl #(.DEPTH(DEPTH), .CW(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
        .out_ready_i(out_ready_i), .eh_maior_i(eh_maior_i),
        .en_sr_o(en_sr_o), .mux_in_o(mux_in_o), .wr_bigger_o(wr_bigger_o),
        .wr_last_o(wr_last_o), .wr_counter_o(wr_counter_o), .rst_counter_o(rst_counter_o),
        .load_ready_o(load_ready_o), .out_valid_o(out_valid_o), .busy_o(busy_o),
        .done_o(done_o)
    );

    function automatic item_t mk(logic [9:0] exp);
        item_t it;
        it.start    = 1'($urandom_range(0, 1));
        it.valid    = 1'($urandom_range(0, 1));
        it.ready    = 1'($urandom_range(0, 1));
        it.eh       = 1'($urandom_range(0, 1));
        it.rst_mid  = 1'b0;
        it.rst_hold = 1'b0;
        it.exp      = exp;
        return it;
    endfunction

    task automatic plan_idle(int n, bit in_reset);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it = mk('0);
            if (in_reset) it.rst_hold = 1'b1;
            else          it.start    = 1'b0;
            plan_q.push_back(it);
        end
    endtask

    task automatic plan_run(int vmode, int emode, int rmode, int abort_at);
        item_t      q[$];
        item_t      it;
        logic [9:0] e;
        int         acc, k;
        bit         b;
        e = '0; e[B_RC] = 1'b1;
        it = mk(e); it.start = 1'b1; q.push_back(it);
        acc = 0; k = 0;
        while (acc < DEPTH) begin
            b = (vmode == 0) ? 1'b1 : (vmode == 1) ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
            e = '0; e[B_BUSY] = 1'b1; e[B_LR] = 1'b1; e[B_EN] = b;
            it = mk(e); it.valid = b; q.push_back(it);
            if (b) acc++;
            k++;
        end
        for (int p = 0; p < DEPTH; p++) begin
            e = '0; e[B_BUSY] = 1'b1; e[B_WB] = 1'b1;
            q.push_back(mk(e));
            for (int c = 0; c < DEPTH; c++) begin
                b = (emode == 0) ? 1'b0 : (emode == 1) ? (c == 1 || c == 4) : 1'($urandom_range(0, 1));
                e = '0; e[B_BUSY] = 1'b1; e[B_EN] = 1'b1; e[B_MUX] = 1'b1; e[B_WB] = b;
                it = mk(e); it.eh = b; q.push_back(it);
            end
            e = '0; e[B_BUSY] = 1'b1; e[B_WL] = 1'b1; e[B_WC] = 1'b1;
            q.push_back(mk(e));
        end
        acc = 0; k = 0;
        while (acc < DEPTH) begin
            b = (rmode == 0) ? 1'b1 : (rmode == 1) ? !(k >= 4 && k < 7) : ($urandom_range(0, 2) != 0);
            e = '0; e[B_BUSY] = 1'b1; e[B_OV] = 1'b1; e[B_MUX] = 1'b1; e[B_EN] = b;
            it = mk(e); it.ready = b; q.push_back(it);
            if (b) acc++;
            k++;
        end
        e = '0; e[B_BUSY] = 1'b1; e[B_DONE] = 1'b1;
        q.push_back(mk(e));
        if (abort_at >= 0 && abort_at < q.size()) begin
            for (int i = 0; i < abort_at; i++) plan_q.push_back(q[i]);
            it = q[abort_at]; it.rst_mid = 1'b1; it.exp = '0;
            plan_q.push_back(it);
            plan_idle(2, 1'b1);
        end else begin
            for (int i = 0; i < q.size(); i++) plan_q.push_back(q[i]);
        end
        plan_idle($urandom_range(1, 3), 1'b0);
    endtask

    always @(negedge clk) begin
        logic [9:0] got, want;
        if (sb_q.size() != 0) begin
            idle_wait = 0;
            want = sb_q.pop_front();
            got  = {en_sr_o, mux_in_o, wr_bigger_o, wr_last_o, wr_counter_o,
                    rst_counter_o, load_ready_o, out_valid_o, busy_o, done_o};
            checks++;
            if (rst) begin
                if (got !== 10'b0) begin
                    $display("FAIL reset-state cyc=%0d got=%b want=0000000000", cyc, got);
                    errors++;
                end else begin
                    $display("cyc=%0d ok reset out=%b", cyc, got);
                end
            end else begin
                if (got !== want) begin
                    $display("FAIL outvec cyc=%0d got=%b want=%b (en,mux,wb,wl,wc,rc,lr,ov,busy,done)",
                             cyc, got, want);
                    errors++;
                end else begin
                    $display("cyc=%0d ok out=%b", cyc, got);
                end
            end
        end else if (running) begin
            idle_wait++;
            if (idle_wait > WAIT_LIMIT) begin
                $display("FAIL expired-wait cyc=%0d no scoreboard progress for %0d cycles",
                         cyc, idle_wait);
                errors++;
                idle_wait = 0;
            end
        end
    end

    initial begin
        item_t it;
        plan_idle(2, 1'b1);
        plan_idle(20, 1'b0);
        plan_run(0, 0, 0, -1);
        plan_run(1, 0, 0, -1);
        plan_run(0, 1, 0, -1);
        plan_run(0, 0, 1, -1);
        plan_run(0, 0, 0, 58);
        plan_run(0, 0, 0, -1);
        for (int r = 0; r < 5; r++) plan_run(2, 2, 2, (r == 2) ? int'($urandom_range(1, 100)) : -1);

        while (plan_q.size() != 0) begin
            @(posedge clk);
            #1;
            it          = plan_q.pop_front();
            start_i     = it.start;
            valid_i     = it.valid;
            out_ready_i = it.ready;
            eh_maior_i  = it.eh;
            rst         = it.rst_hold;
            if (it.rst_mid) begin
                #1 rst = 1'b1;
            end
            sb_q.push_back(it.exp);
        end
        @(negedge clk);
        #1;
        running = 1'b0;
        if (sb_q.size() != 0) begin
            $display("FAIL expired-wait %0d expected transactions never observed", sb_q.size());
            errors++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- FSM controller that sequences the serial sort datapath: a DEPTH-stage shift ring, an input/recirculation mux, and a "bigger" holding register.
- Runs four phases: load DEPTH operands serially; run DEPTH selection passes (compare/rotate, one maximum committed per pass); drain the result; pulse done.
- Sits between the host handshake (start/valid/ready) and the datapath control pins. The datapath's compare flag eh_maior is its only datapath input.

Parameters:
DEPTH, 9, number of shift-ring stages = operands per sort (>=2)
CW, 4, internal counter width (2^CW > DEPTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start_i  in  1  begin sort; sampled only in IDLE
valid_i  in  1  operand present on datapath serial input (LOAD only)
out_ready_i  in  1  consumer accepts drained element (DRAIN only)
eh_maior_i  in  1  datapath flag: ring tail > held bigger value
en_sr_o  out  1  shift-ring enable
mux_in_o  out  1  0 = serial input, 1 = recirculate
wr_bigger_o  out  1  capture ring tail into bigger reg / select it for recirculation
wr_last_o  out  1  commit held maximum (one pulse per pass)
wr_counter_o  out  1  datapath pass-counter increment
rst_counter_o  out  1  datapath counter clear
load_ready_o  out  1  controller accepts operands
out_valid_o  out  1  datapath serial output valid
busy_o  out  1  not IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high): state IDLE; step_cnt = 0; pass_cnt = 0; every output 0. Reset mid-sort aborts immediately, with no pending pulses.
- All outputs are combinational from state, counters and the listed inputs. Outputs not listed for a state are 0.
- IDLE:
  - busy_o = 0.
  - start_i = 1: rst_counter_o = 1 in that same cycle; clear step_cnt and pass_cnt; go to LOAD.
  - valid_i and out_ready_i are ignored.
- LOAD:
  - load_ready_o = 1; mux_in_o = 0; en_sr_o = valid_i.
  - Each accepted operand increments step_cnt.
  - Accept with step_cnt == DEPTH-1: clear step_cnt; go to SEED.
  - valid_i low stalls (no shift, no count).
- SEED (1 cycle): wr_bigger_o = 1, en_sr_o = 0; go to COMP.
- COMP (exactly DEPTH cycles, no stall):
  - en_sr_o = 1; mux_in_o = 1; wr_bigger_o = eh_maior_i (swap when tail is larger, else recirculate tail). step_cnt increments.
  - At step_cnt == DEPTH-1: clear step_cnt; go to LAST.
- LAST (1 cycle): wr_last_o = 1; wr_counter_o = 1; pass_cnt increments.
  - If pass_cnt == DEPTH-1 before the increment: clear pass_cnt; go to DRAIN.
  - Otherwise go to SEED.
- DRAIN:
  - out_valid_o = 1; mux_in_o = 1; en_sr_o = out_ready_i.
  - Each handshake (out_valid_o && out_ready_i) increments step_cnt.
  - Handshake at step_cnt == DEPTH-1: go to DONE.
- DONE (1 cycle): done_o = 1, busy_o = 1; go to IDLE. start_i is not accepted in DONE.
- busy_o = 1 in every state except IDLE.
- start_i while busy: ignored.
- Counters never wrap past DEPTH-1; they are cleared on each phase exit.
- Latency (DEPTH = 9, valid_i and out_ready_i held 1, start sampled at cycle 0):
  - LOAD: cycles 1-9.
  - Pass k (k = 0..8): SEED at 10+11k, COMP at 11+11k..19+11k, LAST at 20+11k.
  - DRAIN: 109-117.
  - done_o at 118.

Test Plan:
- Reset then idle: rst pulse, start_i = 0 for 20 cycles -> all outputs 0, busy_o = 0.
- Nominal run, DEPTH = 9, valid_i and out_ready_i tied 1, start at cycle 0:
  - en_sr_o high 9 cycles (1-9) with mux_in_o = 0.
  - wr_last_o and wr_counter_o pulse at cycles 20, 31, ..., 108 (9 pulses).
  - out_valid_o high 109-117; done_o only at 118.
  - rst_counter_o only at cycle 0.
- LOAD stall: valid_i toggles 1,0,1,0... -> en_sr_o mirrors valid_i; SEED entered after the 9th valid beat (cycle 18 if first valid at 1).
- COMP swap: eh_maior_i = 1 on COMP cycles 2 and 5 only -> wr_bigger_o = 1 on exactly those cycles plus every SEED cycle; no COMP stall from eh_maior_i.
- DRAIN backpressure: out_ready_i low for 3 cycles mid-drain -> out_valid_o stays 1, en_sr_o = 0 during stall, done_o delayed exactly 3 cycles (cycle 121).
- Abort and restart: rst asserted during COMP of pass 4 -> outputs 0 asynchronously. start_i during busy is ignored; after reset a new start produces the full nominal waveform from cycle 0.
